// File: rtl/patram_arbiter.sv
// Shares the single-port pattern RAM between the CPU data port and the blitter read port.
// The blitter wins arbitration, but a waiting CPU access is granted after at most MAX_BLIT_RUN blitter grants.
module patram_arbiter #(
    parameter int ADDR_W          = 14,
    parameter int BLIT_FIFO_DEPTH = 4,
    parameter int MAX_BLIT_RUN    = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpud_request,
    input  logic [15:0]       cpud_addr,
    input  logic              cpud_write,
    input  logic [3:0]        cpud_byte_enable,
    input  logic [31:0]       cpud_wdata,
    output logic [31:0]       cpud_rdata,
    output logic              cpud_ack,
    input  logic              blit_request,
    input  logic [15:0]       blit_addr,
    output logic              blit_ready,
    output logic [31:0]       blit_rdata,
    output logic              blit_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int PTR_W = (BLIT_FIFO_DEPTH > 1) ? $clog2(BLIT_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(BLIT_FIFO_DEPTH + 1);
    localparam int RUN_W = $clog2(MAX_BLIT_RUN + 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(BLIT_FIFO_DEPTH);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_BLIT_RUN);

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_BLIT = 2'b10
    } grant_e;

    logic              r_cpu_pend;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic              r_cpu_we;
    logic [3:0]        r_cpu_be;
    logic [31:0]       r_cpu_wdata;

    logic [ADDR_W-1:0] r_fifo_mem [BLIT_FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fifo_count;
    logic [RUN_W-1:0]  r_run_cnt;

    logic              r_tag_valid;
    logic              r_tag_cpu;

    grant_e            w_grant;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_push;
    logic              w_pop;
    logic              w_unused_addr_bits;

    // Byte-offset bits never reach the word-addressed RAM.
    assign w_unused_addr_bits = ^{cpud_addr[1:0], blit_addr[1:0]};

    assign w_fifo_empty = (r_fifo_count == CNT_W'(0));
    assign w_fifo_full  = (r_fifo_count == FIFO_FULL);
    // Push is gated on the registered count only, so a full queue rejects even with a same-cycle pop.
    assign w_push       = blit_request && !w_fifo_full;
    assign w_pop        = (w_grant == GNT_BLIT);

    // Arbitration: CPU only when the queue is idle or the blitter has used up its run.
    always_comb begin
        w_grant = GNT_NONE;
        if (r_cpu_pend && (w_fifo_empty || (r_run_cnt == RUN_MAX))) begin
            w_grant = GNT_CPU;
        end else if (!w_fifo_empty) begin
            w_grant = GNT_BLIT;
        end else begin
            w_grant = GNT_NONE;
        end
    end

    // RAM port drive from the granted source.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_be    = 4'b0000;
        ram_wdata = 32'h0000_0000;
        case (w_grant)
            GNT_CPU: begin
                ram_en    = 1'b1;
                ram_we    = r_cpu_we;
                ram_addr  = r_cpu_addr;
                ram_be    = r_cpu_we ? r_cpu_be : 4'b1111;
                ram_wdata = r_cpu_wdata;
            end
            GNT_BLIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b0;
                ram_addr  = r_fifo_mem[r_rd_ptr];
                ram_be    = 4'b1111;
                ram_wdata = 32'h0000_0000;
            end
            default: begin
                ram_en    = 1'b0;
            end
        endcase
    end

    // CPU pending register: one outstanding access, a new request while pending is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_pend  <= 1'b0;
            r_cpu_addr  <= {ADDR_W{1'b0}};
            r_cpu_we    <= 1'b0;
            r_cpu_be    <= 4'b0000;
            r_cpu_wdata <= 32'h0000_0000;
        end else if (w_grant == GNT_CPU) begin
            r_cpu_pend  <= 1'b0;
        end else if (cpud_request && !r_cpu_pend) begin
            r_cpu_pend  <= 1'b1;
            r_cpu_addr  <= cpud_addr[ADDR_W+1:2];
            r_cpu_we    <= cpud_write;
            r_cpu_be    <= cpud_byte_enable;
            r_cpu_wdata <= cpud_wdata;
        end
    end

    // Blitter queue storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= blit_addr[ADDR_W+1:2];
        end
    end

    // Blitter queue pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_fifo_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Consecutive blitter grants taken while the CPU is waiting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run_cnt <= {RUN_W{1'b0}};
        end else begin
            case (w_grant)
                GNT_BLIT: begin
                    if (!r_cpu_pend) begin
                        r_run_cnt <= {RUN_W{1'b0}};
                    end else if (r_run_cnt != RUN_MAX) begin
                        r_run_cnt <= r_run_cnt + RUN_W'(1);
                    end
                end
                default: r_run_cnt <= {RUN_W{1'b0}};
            endcase
        end
    end

    // In-flight tag: one grant per cycle, so one entry steers the next-cycle ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_valid <= 1'b0;
            r_tag_cpu   <= 1'b0;
        end else begin
            r_tag_valid <= (w_grant != GNT_NONE);
            r_tag_cpu   <= (w_grant == GNT_CPU);
        end
    end

    assign cpud_ack   = r_tag_valid && r_tag_cpu;
    assign blit_ack   = r_tag_valid && !r_tag_cpu;
    assign cpud_rdata = cpud_ack ? ram_rdata : 32'h0000_0000;
    assign blit_rdata = blit_ack ? ram_rdata : 32'h0000_0000;
    assign blit_ready = !w_fifo_full;

endmodule

// File: tb/tb_patram_arbiter.sv
// Self-checking bench for patram_arbiter: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model and a golden memory image.
module tb_patram_arbiter;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 2;
    localparam int MAXRUN = 8;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cpud_request;
    logic [15:0]       cpud_addr;
    logic              cpud_write;
    logic [3:0]        cpud_byte_enable;
    logic [31:0]       cpud_wdata;
    logic [31:0]       cpud_rdata;
    logic              cpud_ack;
    logic              blit_request;
    logic [15:0]       blit_addr;
    logic              blit_ready;
    logic [31:0]       blit_rdata;
    logic              blit_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    patram_arbiter #(
        .ADDR_W(ADDR_W), .BLIT_FIFO_DEPTH(DEPTH), .MAX_BLIT_RUN(MAXRUN)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
        .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
        .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
        .blit_request(blit_request), .blit_addr(blit_addr), .blit_ready(blit_ready),
        .blit_rdata(blit_rdata), .blit_ack(blit_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // Environment RAM: read-before-write, data one cycle after ram_en.
    logic [31:0] ram_mem [WORDS];
    always @(posedge clock) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model state.
    logic [31:0]       gold [WORDS];
    bit                m_pend;
    logic [ADDR_W-1:0] m_caddr;
    bit                m_cwe;
    logic [3:0]        m_cbe;
    logic [31:0]       m_cwd;
    logic [ADDR_W-1:0] m_bq [$];
    int                m_wait;
    bit                m_tag_v;
    bit                m_tag_cpu;
    logic [31:0]       m_tag_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 1'b0;
        m_bq.delete();
        m_wait  = 0;
        m_tag_v = 1'b0;
        m_tag_cpu = 1'b0;
        m_tag_data = 32'h0;
    endtask

    task automatic clear_inputs();
        cpud_request = 1'b0; cpud_addr = 16'h0; cpud_write = 1'b0;
        cpud_byte_enable = 4'h0; cpud_wdata = 32'h0;
        blit_request = 1'b0; blit_addr = 16'h0;
    endtask

    // Called at posedge+1: compare outputs with the model, then advance the model across the next edge.
    task automatic cycle();
        bit g_cpu, g_blit, pre_pend;
        int pre_size;
        logic [ADDR_W-1:0] ga;
        g_cpu  = m_pend && (m_bq.size() == 0 || m_wait == MAXRUN);
        g_blit = !g_cpu && (m_bq.size() != 0);
        ga     = g_cpu ? m_caddr : ((m_bq.size() != 0) ? m_bq[0] : '0);
        check("blit_ready", 32'(blit_ready), 32'(m_bq.size() < DEPTH));
        check("ram_en", 32'(ram_en), 32'(g_cpu || g_blit));
        check("ram_we", 32'(ram_we), 32'(g_cpu && m_cwe));
        if (g_cpu || g_blit) begin
            check("ram_addr", 32'(ram_addr), 32'(ga));
            check("ram_be", 32'(ram_be), 32'((g_cpu && m_cwe) ? m_cbe : 4'hF));
        end
        if (g_cpu && m_cwe) check("ram_wdata", ram_wdata, m_cwd);
        check("cpud_ack", 32'(cpud_ack), 32'(m_tag_v && m_tag_cpu));
        check("blit_ack", 32'(blit_ack), 32'(m_tag_v && !m_tag_cpu));
        check("cpud_rdata", cpud_rdata, (m_tag_v && m_tag_cpu) ? m_tag_data : 32'h0);
        check("blit_rdata", blit_rdata, (m_tag_v && !m_tag_cpu) ? m_tag_data : 32'h0);

        pre_pend = m_pend;
        pre_size = m_bq.size();
        m_tag_v   = g_cpu || g_blit;
        m_tag_cpu = g_cpu;
        if (g_cpu) begin
            m_tag_data = gold[m_caddr];
            if (m_cwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_cbe[b]) gold[m_caddr][8*b +: 8] = m_cwd[8*b +: 8];
                end
            end
            m_pend = 1'b0;
            m_wait = 0;
        end else if (g_blit) begin
            m_tag_data = gold[m_bq[0]];
            void'(m_bq.pop_front());
            m_wait = pre_pend ? ((m_wait < MAXRUN) ? m_wait + 1 : MAXRUN) : 0;
        end else begin
            m_wait = 0;
        end
        if (cpud_request && !pre_pend) begin
            m_pend  = 1'b1;
            m_caddr = cpud_addr[ADDR_W+1:2];
            m_cwe   = cpud_write;
            m_cbe   = cpud_byte_enable;
            m_cwd   = cpud_wdata;
        end
        if (blit_request && pre_size < DEPTH) m_bq.push_back(blit_addr[ADDR_W+1:2]);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        for (int i = 0; i < n; i++) begin
            check("rst_blit_ready", 32'(blit_ready), 32'd1);
            check("rst_ram_en", 32'(ram_en), 32'd0);
            check("rst_cpud_ack", 32'(cpud_ack), 32'd0);
            check("rst_blit_ack", 32'(blit_ack), 32'd0);
            check("rst_rdata", cpud_rdata | blit_rdata, 32'h0);
            @(posedge clock);
            #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic cpu_req(input logic [15:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        cpud_request = 1'b1; cpud_addr = a; cpud_write = w;
        cpud_byte_enable = be; cpud_wdata = d;
        cycle();
        cpud_request = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = 32'(i) * 32'h9E37_79B1;
            gold[i]    = 32'(i) * 32'h9E37_79B1;
        end
        clear_inputs();
        do_reset(3);

        // Full-word write then readback.
        cpu_req(16'h1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
        idle(3);
        cpu_req(16'h1000, 1'b0, 4'hF, 32'h0);
        idle(3);

        // Single-lane write, readback keeps the other bytes.
        cpu_req(16'h0004, 1'b1, 4'b0010, 32'h0000_AB00);
        idle(3);
        cpu_req(16'h0004, 1'b0, 4'hF, 32'h0);
        idle(3);

        // Four back-to-back blitter reads.
        for (int i = 0; i < 4; i++) begin
            blit_request = 1'b1;
            blit_addr = 16'(i * 4);
            cycle();
        end
        blit_request = 1'b0;
        idle(4);

        // Continuous blitter traffic with a CPU read at cycle 3: starvation bound and queue-full.
        for (int i = 0; i < 20; i++) begin
            blit_request = 1'b1;
            blit_addr = 16'(16'h0040 + 16'(i * 4));
            cpud_request = (i == 3);
            cpud_addr = 16'h1000; cpud_write = 1'b0; cpud_byte_enable = 4'hF;
            cycle();
        end
        clear_inputs();
        idle(4);

        // Continuous blitter traffic with a CPU write and a later CPU read.
        for (int i = 0; i < 30; i++) begin
            blit_request = 1'b1;
            blit_addr = 16'(16'h0100 + 16'(i * 4));
            cpud_request = (i == 2 || i == 15) && !m_pend;
            cpud_addr = 16'h0100;
            cpud_write = (i == 2);
            cpud_byte_enable = 4'b1001;
            cpud_wdata = 32'h1122_3344;
            cycle();
        end
        clear_inputs();
        idle(4);

        // Reset the cycle after a CPU grant, then a fresh access.
        cpu_req(16'h2000, 1'b0, 4'hF, 32'h0);
        cycle();
        do_reset(2);
        cpu_req(16'h2000, 1'b0, 4'hF, 32'h0);
        idle(3);

        // Random mixed traffic.
        for (int k = 0; k < 2000; k++) begin
            cpud_request     = !m_pend && ($urandom_range(0, 3) == 0);
            cpud_addr        = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 127));
            cpud_write       = 1'($urandom_range(0, 1));
            cpud_byte_enable = 4'($urandom_range(0, 15));
            cpud_wdata       = $urandom();
            blit_request     = ($urandom_range(0, 2) != 0);
            blit_addr        = 16'($urandom_range(0, 127));
            if (k == 700 || k == 1400) do_reset(2);
            else cycle();
        end
        clear_inputs();
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
